// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier control slice:
// FSM state encoding and the ceiling-log2 helper used to size counters.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Number of bits needed to represent values 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spm_bitcnt.sv
// Shift-cycle counter for the serial multiplier: counts 0..2*WIDTH-1,
// flags the final count and rolls over to 0 after it.
module spm_bitcnt
    import spm_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and roll over after the last shift.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for a serial-parallel multiplier datapath: accepts an operand
// pair, issues one load/clear cycle, 2*WIDTH shift cycles, then holds the
// product valid until the consumer takes it. Control only, no datapath.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_mode,
    input  logic             abort,
    output logic             ld,
    output logic             clr,
    output logic             shift,
    output logic [CNT_W-1:0] bit_idx,
    output logic             sign_ext,
    output logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Counts at or above this value are in the upper half of the product,
    // where a signed serial operand must be sign-extended.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic             signed_q;
    logic             signed_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
    logic             accept;

    spm_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (ld),
        .en   (shift),
        .cnt  (cnt),
        .wrap (cnt_wrap)
    );

    // A finished product frees the controller in the same cycle it is taken,
    // which lets a new operand pair enter with no bubble.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Outputs are pure decodes of registered state and count.
    assign ld        = (state_q == LOAD);
    assign clr       = (state_q == LOAD);
    assign shift     = (state_q == SHIFT);
    assign bit_idx   = cnt;
    assign last      = shift && cnt_wrap;
    assign sign_ext  = signed_q && shift && (cnt >= CNT_HALF);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == LOAD) || (state_q == SHIFT);

    // Next-state logic; abort only matters while an operation is running.
    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = LOAD;
                    signed_d = signed_mode;
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_wrap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d  = LOAD;
                        signed_d = signed_mode;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand-signedness registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
        end
    end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Self-checking bench for spm_seq_ctrl: table-driven operation scenarios,
// hand-written corner sequences, and a randomized run against a
// cycle-since-accept timeline model.
module tb_spm_seq_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       signed_mode;
    logic       abort;
    logic       ld;
    logic       clr;
    logic       shift;
    logic [3:0] bit_idx;
    logic       sign_ext;
    logic       last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    // Extra builds for the width extremes.
    logic       w2_in_valid;
    logic       w2_in_ready, w2_ld, w2_clr, w2_shift, w2_sign_ext, w2_last, w2_out_valid, w2_busy;
    logic [1:0] w2_bit_idx;
    logic       w64_in_valid;
    logic       w64_in_ready, w64_ld, w64_clr, w64_shift, w64_sign_ext, w64_last, w64_out_valid, w64_busy;
    logic [6:0] w64_bit_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spm_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .abort(abort), .ld(ld), .clr(clr), .shift(shift),
        .bit_idx(bit_idx), .sign_ext(sign_ext), .last(last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    spm_seq_ctrl #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .signed_mode(1'b1), .abort(1'b0), .ld(w2_ld), .clr(w2_clr), .shift(w2_shift),
        .bit_idx(w2_bit_idx), .sign_ext(w2_sign_ext), .last(w2_last), .out_valid(w2_out_valid),
        .out_ready(1'b1), .busy(w2_busy)
    );

    spm_seq_ctrl #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(w64_in_valid), .in_ready(w64_in_ready),
        .signed_mode(1'b1), .abort(1'b0), .ld(w64_ld), .clr(w64_clr), .shift(w64_shift),
        .bit_idx(w64_bit_idx), .sign_ext(w64_sign_ext), .last(w64_last), .out_valid(w64_out_valid),
        .out_ready(1'b1), .busy(w64_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_ld"},        64'(ld),        64'd0);
        check({tag, "_clr"},       64'(clr),       64'd0);
        check({tag, "_shift"},     64'(shift),     64'd0);
        check({tag, "_bit_idx"},   64'(bit_idx),   64'd0);
        check({tag, "_sign_ext"},  64'(sign_ext),  64'd0);
        check({tag, "_last"},      64'(last),      64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // One scenario: accept at cycle 0, optional abort during cycle abort_at,
    // product held (out_ready low) so the first out_valid cycle is visible.
    typedef struct {
        logic sm;
        int   abort_at;
        int   exp_shifts;
        int   exp_sext;
        int   exp_first_ov;
    } vec_t;

    task automatic run_scenario(input string tag, input vec_t v);
        int shifts, sexts, sext_bad, idx_bad, ld_bad, last_bad, first_ov;
        shifts = 0; sexts = 0; sext_bad = 0; idx_bad = 0; ld_bad = 0; last_bad = 0;
        first_ov = -1;
        @(negedge clk);
        in_valid = 1'b1; signed_mode = v.sm; out_ready = 1'b0; abort = 1'b0;
        #1 check({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            abort = (c == v.abort_at);
            #1;
            if (ld !== (c == 1) || clr !== (c == 1)) ld_bad++;
            if (shift) begin
                shifts++;
                if (int'(bit_idx) != c - 2) idx_bad++;
            end
            if (sign_ext) begin
                sexts++;
                if (bit_idx < 4'd8) sext_bad++;
            end
            if (last && c != 2 * W + 1) last_bad++;
            if (out_valid && first_ov < 0) first_ov = c;
            if (v.abort_at > 0 && c == v.abort_at + 1) begin
                check({tag, "_post_abort_shift"},    64'(shift),    64'd0);
                check({tag, "_post_abort_in_ready"}, 64'(in_ready), 64'd1);
            end
        end
        abort = 1'b0;
        check({tag, "_shift_count"}, 64'(shifts),   64'(v.exp_shifts));
        check({tag, "_sext_count"},  64'(sexts),    64'(v.exp_sext));
        check({tag, "_sext_low"},    64'(sext_bad), 64'd0);
        check({tag, "_bit_idx"},     64'(idx_bad),  64'd0);
        check({tag, "_ld_timing"},   64'(ld_bad),   64'd0);
        check({tag, "_last_timing"}, 64'(last_bad), 64'd0);
        check({tag, "_first_ov"},    64'(first_ov), 64'(v.exp_first_ov));
        if (first_ov > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            #1 check({tag, "_released"}, 64'({out_valid, in_ready}), 64'b01);
        end
    endtask

    // Run one operation on a width-extreme build and count its shift cycles.
    task automatic run_width(input string tag, input bit sel, input int exp_shifts);
        int  shifts, first_idx, last_idx;
        bit  seen_ov;
        shifts = 0; first_idx = -1; last_idx = -1; seen_ov = 1'b0;
        @(negedge clk);
        if (sel) w64_in_valid = 1'b1; else w2_in_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400 && !seen_ov; c++) begin
            @(negedge clk);
            w2_in_valid = 1'b0; w64_in_valid = 1'b0;
            #1;
            if (sel ? w64_shift : w2_shift) begin
                shifts++;
                last_idx = sel ? int'(w64_bit_idx) : int'(w2_bit_idx);
                if (first_idx < 0) first_idx = last_idx;
            end
            seen_ov = sel ? w64_out_valid : w2_out_valid;
        end
        check({tag, "_done_seen"}, 64'(seen_ov),   64'd1);
        check({tag, "_shifts"},    64'(shifts),    64'(exp_shifts));
        check({tag, "_first_idx"}, 64'(first_idx), 64'd0);
        check({tag, "_last_idx"},  64'(last_idx),  64'(exp_shifts - 1));
    endtask

    // Bounded wait on the main DUT for a held product.
    task automatic wait_out_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1 seen = out_valid;
        end
        check({tag, "_ov_reached"}, 64'(seen), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        int hold_bad;
        bit found;
        int k;
        bit sgn;
        bit m_ld, m_shift, m_last, m_sext, m_ov, m_busy, m_ready, acc;

        vecs[0] = '{sm: 1'b0, abort_at: -1, exp_shifts: 16, exp_sext: 0, exp_first_ov: 18};
        vecs[1] = '{sm: 1'b1, abort_at: -1, exp_shifts: 16, exp_sext: 8, exp_first_ov: 18};
        vecs[2] = '{sm: 1'b0, abort_at: 7,  exp_shifts: 6,  exp_sext: 0, exp_first_ov: -1};
        vecs[3] = '{sm: 1'b1, abort_at: 17, exp_shifts: 16, exp_sext: 8, exp_first_ov: -1};
        vecs[4] = '{sm: 1'b1, abort_at: 1,  exp_shifts: 0,  exp_sext: 0, exp_first_ov: -1};
        vecs[5] = '{sm: 1'b1, abort_at: 12, exp_shifts: 11, exp_sext: 3, exp_first_ov: -1};

        rst_n = 1'b0;
        in_valid = 1'b0; signed_mode = 1'b0; abort = 1'b0; out_ready = 1'b0;
        w2_in_valid = 1'b0; w64_in_valid = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_scenario($sformatf("vec%0d", i), vecs[i]);
        end

        // Product held with out_ready low; in_valid and abort must be ignored.
        @(negedge clk);
        in_valid = 1'b1; signed_mode = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out_valid("hold");
        hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1)); abort = 1'b1; out_ready = 1'b0;
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) hold_bad++;
        end
        check("hold_done_10", 64'(hold_bad), 64'd0);
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b1; in_valid = 1'b1; signed_mode = 1'b1;
        #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("b2b_ld", 64'({ld, clr, out_valid}), 64'b110);
        wait_out_valid("b2b");
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of the shift phase.
        @(negedge clk);
        in_valid = 1'b1; signed_mode = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            #1 found = shift && (bit_idx == 4'd9);
        end
        check("rst_reach_idx9", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_scenario("after_rst", vecs[0]);

        // Width extremes, twice each so the count must restart from 0.
        run_width("w2_a", 1'b0, 4);
        run_width("w2_b", 1'b0, 4);
        run_width("w64_a", 1'b1, 128);
        run_width("w64_b", 1'b1, 128);

        // Randomized run against a timeline model: k counts cycles since the
        // last accept (k=1 load, k=2..2W+1 shift, k>=2W+2 product held),
        // k<0 means idle.
        k = -1; sgn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            signed_mode = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            abort       = ($urandom_range(0, 15) == 0);
            #1;
            m_ld    = (k == 1);
            m_shift = (k >= 2) && (k <= 2 * W + 1);
            m_last  = (k == 2 * W + 1);
            m_sext  = sgn && m_shift && (k - 2 >= W);
            m_ov    = (k >= 2 * W + 2);
            m_busy  = m_ld || m_shift;
            m_ready = (k < 0) || (m_ov && out_ready);
            check("rnd_in_ready",  64'(in_ready),  64'(m_ready));
            check("rnd_ld",        64'(ld),        64'(m_ld));
            check("rnd_clr",       64'(clr),       64'(m_ld));
            check("rnd_shift",     64'(shift),     64'(m_shift));
            check("rnd_last",      64'(last),      64'(m_last));
            check("rnd_sign_ext",  64'(sign_ext),  64'(m_sext));
            check("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            check("rnd_busy",      64'(busy),      64'(m_busy));
            if (m_shift) check("rnd_bit_idx", 64'(bit_idx), 64'(k - 2));
            @(posedge clk);
            acc = in_valid && m_ready;
            if (m_busy && abort) begin
                k = -1;
            end else if (acc) begin
                k = 1;
                sgn = signed_mode;
            end else if (m_ov) begin
                if (out_ready) k = -1;
            end else if (k >= 1) begin
                k = k + 1;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spm_seq_ctrl.md
SPM_SEQ_CTRL -- requirements
Module: spm_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 SHALL have localparam CNT_W, equal to clog2(2*WIDTH), the width of the shift counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: new operand pair available.
REQ-006 SHALL have port in_ready, output, 1 bit: controller accepts an operand pair this cycle.
REQ-007 SHALL have port signed_mode, input, 1 bit: operand signedness, sampled on accept.
REQ-008 SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-009 SHALL have port ld, output, 1 bit: load operand registers.
REQ-010 SHALL have port clr, output, 1 bit: clear product accumulator.
REQ-011 SHALL have port shift, output, 1 bit: advance the serial datapath one bit.
REQ-012 SHALL have port bit_idx, output, CNT_W bits: index of the current shift cycle.
REQ-013 SHALL have port sign_ext, output, 1 bit: datapath replicates the serial-operand MSB.
REQ-014 SHALL have port last, output, 1 bit: final shift cycle.
REQ-015 SHALL have port out_valid, output, 1 bit: product complete and held.
REQ-016 SHALL have port out_ready, input, 1 bit: consumer takes the product.
REQ-017 SHALL have port busy, output, 1 bit: state is LOAD or SHIFT.

Function
REQ-018 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-019 Accept SHALL occur when in_valid && in_ready.
- in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-020 On accept, the FSM SHALL go to LOAD next cycle and register signed_mode into an internal signed_q.
REQ-021 LOAD SHALL last exactly one cycle.
- ld=1, clr=1.
- Counter cleared to 0.
- Next state is SHIFT.
REQ-022 SHIFT SHALL last exactly 2*WIDTH cycles.
- shift=1.
- bit_idx = counter, counting 0..2*WIDTH-1.
- Counter increments each cycle.
REQ-023 last SHALL be 1 only in SHIFT with counter==2*WIDTH-1; the next state is then DONE.
REQ-024 sign_ext SHALL be signed_q && shift && (counter>=WIDTH); it SHALL be 0 in unsigned mode.
REQ-025 DONE SHALL hold out_valid=1 until out_ready is 1.
- Exit to IDLE on out_ready without accept.
- Exit to LOAD on out_ready with accept (back-to-back operation, zero bubble).
REQ-026 Latency: accept at cycle t gives ld at t+1, shift over t+2..t+1+2*WIDTH, and out_valid first at t+2+2*WIDTH.
REQ-027 abort in LOAD or SHIFT SHALL force IDLE next cycle with no out_valid.
- Abort wins over last in the same cycle.
- Abort SHALL be ignored in IDLE and DONE.
REQ-028 in_valid SHALL be ignored while in_ready=0; it SHALL NOT be queued.
REQ-029 In IDLE, ld, clr and shift SHALL all be 0 (the datapath holds).
REQ-030 Illegal state encodings SHALL recover to IDLE on the next cycle.
REQ-031 All outputs SHALL be decoded combinationally from registered state and counter only (no input-to-output path), except in_ready, which depends on out_ready.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, counter=0 and signed_q=0, independent of clk.
REQ-033 Output values in reset SHALL be: in_ready=1, ld=0, clr=0, shift=0, bit_idx=0, sign_ext=0, last=0, out_valid=0, busy=0.
REQ-034 Reset deassertion mid-operation SHALL leave no residue; the first accept after release SHALL follow REQ-026 exactly.

Structure
REQ-035 State encoding SHALL live in the shared package spm_pkg (IDLE=0, LOAD=1, SHIFT=2, DONE=3), together with the clog2 helper function.
REQ-036 The shift counter SHALL be a sub-module spm_bitcnt (parameter WIDTH; ports clr, en, cnt, wrap).
- The FSM SHALL remain in spm_seq_ctrl.
REQ-037 The block SHALL contain no datapath; it drives control of the existing serial-parallel multiplier datapath only.

Verification
REQ-038 WIDTH=8, unsigned, accept at cycle 0 -> ld/clr at cycle 1; shift cycles 2..17 with bit_idx 0..15; last at 17; out_valid from 18.
REQ-039 WIDTH=8, signed_mode=1 -> sign_ext=1 exactly for bit_idx 8..15; repeat with signed_mode=0 -> sign_ext never 1.
REQ-040 abort at bit_idx=5 -> shift=0 and in_ready=1 next cycle; out_valid never asserts; abort coincident with last -> no out_valid.
REQ-041 out_ready held low 10 cycles in DONE -> out_valid stays 1 and in_ready=0; out_ready=1 with in_valid=1 -> ld the next cycle (back-to-back).
REQ-042 rst_n pulsed low at bit_idx=9 -> all outputs at reset values asynchronously; after release, a new accept at cycle 0 reproduces the REQ-038 timing.
REQ-043 WIDTH=2 and WIDTH=64 builds -> 4 and 128 shift cycles respectively; bit_idx wraps to 0 on the next LOAD.
